aurora_rx_frame_filter: RTL and testbench
=========================================

Name: aurora_rx_frame_filter

Overview:
- Sits directly downstream of the Aurora RX CRC checker.
- Stores each received frame in a packet FIFO and commits it to the user AXI-Stream side only when the checker reports CRC pass and no length error on the last beat.
- Discards failed, overflowed or interrupted frames entirely and counts them.
- Adds backpressure (m_axis_tready), which the Aurora RX path lacks.

Parameters:
ADDR_BITS, 9, FIFO depth = 2^ADDR_BITS words of {tdata, tkeep, tuser, tlast}; frames longer than the depth are always dropped.
CNT_BITS, 16, width of each saturating statistics counter.

Ports:
s_axis_aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
channel_up  in  1  Aurora channel up; low aborts the frame in progress
s_axis_tdata  in  32  data from CRC checker
s_axis_tkeep  in  4  byte enables
s_axis_tuser  in  1  user flag, stored per word
s_axis_tlast  in  1  last data beat; coincides with crc_valid
s_axis_tvalid  in  1  beat valid (no ready; must always be accepted)
s_axis_crc_valid  in  1  CRC verdict valid
s_axis_crc_pass_fail_n  in  1  1 = CRC pass
s_axis_length_err  in  1  trailer length error
m_axis_tdata  out  32  committed data
m_axis_tkeep  out  4  committed tkeep
m_axis_tuser  out  1  committed tuser
m_axis_tlast  out  1  frame end
m_axis_tvalid  out  1  committed word available
m_axis_tready  in  1  consumer ready
good_frames  out  CNT_BITS  frames committed
crc_err_frames  out  CNT_BITS  frames dropped: CRC fail, length error, or missing crc_valid
ovf_frames  out  CNT_BITS  frames dropped for FIFO overflow or channel_up loss
frame_dropped  out  1  one-cycle pulse on any drop

Behaviour:
- Reset (aresetn low, asynchronous): wr_ptr, commit_ptr, rd_ptr, ovf flag and all counters are 0. m_axis_tvalid=0. frame_dropped=0. FIFO contents are don't-care.
- Pointers are ADDR_BITS+1 bits wide.
  - Write-full: wr_ptr-rd_ptr == 2^ADDR_BITS.
  - Read-empty: rd_ptr == commit_ptr.
- Write side, on each beat (s_axis_tvalid && channel_up):
  - If not full and ovf flag clear: write the word at wr_ptr and increment wr_ptr.
  - If full: set the ovf flag, do not write, do not increment.
  - The tlast beat is itself a data word and is written under the same rule.
- Verdict, evaluated on a tlast beat after the above:
  - Commit when crc_valid && crc_pass_fail_n && !length_err && ovf flag clear (including the case where the tlast word itself fits). Then commit_ptr <= wr_ptr+1 (the pointer including the tlast word) and good_frames increments.
  - Otherwise: wr_ptr <= commit_ptr and frame_dropped pulses.
    - ovf flag set or tlast word did not fit: ovf_frames increments.
    - Else: crc_err_frames increments.
  - In both cases the ovf flag clears.
- channel_up low:
  - wr_ptr <= commit_ptr and the ovf flag clears.
  - If wr_ptr != commit_ptr (frame in progress), ovf_frames increments and frame_dropped pulses once, on the first low cycle only.
  - s_axis beats are ignored while channel_up is low.
  - Committed frames stay readable.
- Read side, first-word fall-through:
  - m_axis_tvalid = (rd_ptr != commit_ptr). m_axis_* are read asynchronously from the distributed RAM at rd_ptr.
  - rd_ptr increments on tvalid && tready.
  - Outputs hold stable while tvalid && !tready.
- Latency: a frame's first word appears on m_axis in the cycle after the clock edge that sampled its tlast beat. No word of an uncommitted frame is ever visible.
- Simultaneous events:
  - Read and write in the same cycle are both performed.
  - Full is evaluated with the pre-edge rd_ptr, so a concurrent read does not free space for that beat.
  - Commit and read in the same cycle are both performed.
- Counters saturate at all-ones; they do not wrap.
- Pointer arithmetic wraps modulo 2^(ADDR_BITS+1).

Test Plan:
- 4-beat frame (0x11111111..0x44444444), pass=1, length_err=0, tready=1 -> no m_axis_tvalid during input; 4 words out on consecutive cycles starting the cycle after tlast, tlast on 0x44444444; good_frames=1.
- Same frame with crc_pass_fail_n=0 -> nothing output; crc_err_frames=1; frame_dropped pulse; wr_ptr back to its start value. Repeat with length_err=1 -> crc_err_frames=2.
- ADDR_BITS=3, tready=0, a 6-word good frame then a 5-word frame -> first commits; second overflows at word 3 and is dropped (ovf_frames=1); then raise tready -> exactly 6 words out.
- channel_up drops after 2 beats of a frame -> ovf_frames=1, one frame_dropped pulse; next good 3-word frame is output intact.
- Good frame with tready toggling 1,0,0,1 -> data held stable while stalled; no word lost or duplicated.
- Assert aresetn low mid-output -> m_axis_tvalid=0 immediately; counters 0; next frame behaves as in scenario 1.

Source files
------------

// File: rtl/aurora_rx_frame_filter_if.sv
// Stream bundle shared by both sides of the Aurora RX frame filter.
// Carries an AXI-Stream beat plus the CRC-checker trailer verdict.
//   tdata/tkeep/tuser/tlast/tvalid : beat payload and qualifier (master -> slave)
//   tready                         : consumer ready (slave -> master)
//   crc_valid/crc_pass_fail_n      : CRC verdict on the tlast beat (master -> slave)
//   length_err                     : trailer length error on the tlast beat (master -> slave)
interface aurora_rx_frame_filter_if;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tuser;
  logic        tlast;
  logic        tvalid;
  logic        tready;
  logic        crc_valid;
  logic        crc_pass_fail_n;
  logic        length_err;

  modport master (
    output tdata, tkeep, tuser, tlast, tvalid, crc_valid, crc_pass_fail_n, length_err,
    input  tready
  );

  modport slave (
    input  tdata, tkeep, tuser, tlast, tvalid, crc_valid, crc_pass_fail_n, length_err,
    output tready
  );
endinterface

// File: rtl/aurora_rx_frame_filter.sv
// Aurora RX frame filter: buffers each frame from the CRC checker in a packet FIFO and
// releases it to the AXI-Stream consumer only when the trailer verdict is clean.
// Failed, overflowed or channel-interrupted frames are discarded and counted.
//   s_axis_aclk, aresetn : clock, asynchronous active-low reset
//   channel_up           : Aurora channel status; low aborts the frame in progress
//   s_axis               : input beats + CRC verdict (no backpressure, tready tied high)
//   m_axis               : committed output stream, first-word fall-through
//   good_frames          : saturating count of committed frames
//   crc_err_frames       : saturating count of CRC / length / missing-verdict drops
//   ovf_frames           : saturating count of overflow / channel-loss drops
//   frame_dropped        : one-cycle pulse per dropped frame
module aurora_rx_frame_filter #(
  parameter int unsigned ADDR_BITS = 9,
  parameter int unsigned CNT_BITS  = 16
) (
  input  logic                    s_axis_aclk,
  input  logic                    aresetn,
  input  logic                    channel_up,
  aurora_rx_frame_filter_if.slave  s_axis,
  aurora_rx_frame_filter_if.master m_axis,
  output logic [CNT_BITS-1:0]     good_frames,
  output logic [CNT_BITS-1:0]     crc_err_frames,
  output logic [CNT_BITS-1:0]     ovf_frames,
  output logic                    frame_dropped
);

  localparam int unsigned Depth = 1 << ADDR_BITS;
  localparam int unsigned PtrW  = ADDR_BITS + 1;
  typedef logic [PtrW-1:0] ptr_t;
  localparam ptr_t DepthPtr = ptr_t'(Depth);

  // Word layout: {tuser, tlast, tkeep, tdata}
  logic [37:0] mem [Depth];

  ptr_t wr_ptr_q, wr_ptr_d, commit_ptr_q, commit_ptr_d, rd_ptr_q, rd_ptr_d;
  logic ovf_q, ovf_d;
  logic [CNT_BITS-1:0] good_q, good_d, crc_q, crc_d, ovfc_q, ovfc_d;
  logic drop_q, drop_d;

  logic beat, full, do_write, rd_fire;

  function automatic logic [CNT_BITS-1:0] sat_inc(input logic [CNT_BITS-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign beat     = s_axis.tvalid & channel_up;
  // Full uses the pre-edge rd_ptr, so a concurrent read never frees space for this beat.
  assign full     = (wr_ptr_q - rd_ptr_q) == DepthPtr;
  assign do_write = beat & ~full & ~ovf_q;
  assign rd_fire  = m_axis.tvalid & m_axis.tready;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    commit_ptr_d = commit_ptr_q;
    ovf_d        = ovf_q;
    good_d       = good_q;
    crc_d        = crc_q;
    ovfc_d       = ovfc_q;
    drop_d       = 1'b0;
    rd_ptr_d     = rd_fire ? rd_ptr_q + 1'b1 : rd_ptr_q;

    if (!channel_up) begin
      wr_ptr_d = commit_ptr_q;
      ovf_d    = 1'b0;
      // After the first low cycle wr_ptr == commit_ptr, so this fires only once per loss.
      if (wr_ptr_q != commit_ptr_q) begin
        ovfc_d = sat_inc(ovfc_q);
        drop_d = 1'b1;
      end
    end else if (beat) begin
      if (full)     ovf_d    = 1'b1;
      if (do_write) wr_ptr_d = wr_ptr_q + 1'b1;
      if (s_axis.tlast) begin
        ovf_d = 1'b0;
        // do_write implies the ovf flag was clear and the tlast word itself fit.
        if (s_axis.crc_valid && s_axis.crc_pass_fail_n && !s_axis.length_err && do_write) begin
          commit_ptr_d = wr_ptr_q + 1'b1;
          good_d       = sat_inc(good_q);
        end else begin
          wr_ptr_d = commit_ptr_q;
          drop_d   = 1'b1;
          if (ovf_q || full) ovfc_d = sat_inc(ovfc_q);
          else               crc_d  = sat_inc(crc_q);
        end
      end
    end
  end

  always_ff @(posedge s_axis_aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      ovf_q        <= 1'b0;
      good_q       <= '0;
      crc_q        <= '0;
      ovfc_q       <= '0;
      drop_q       <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      ovf_q        <= ovf_d;
      good_q       <= good_d;
      crc_q        <= crc_d;
      ovfc_q       <= ovfc_d;
      drop_q       <= drop_d;
    end
  end

  // Storage is not reset; visibility is governed entirely by the pointers.
  always_ff @(posedge s_axis_aclk) begin
    if (do_write) begin
      mem[wr_ptr_q[ADDR_BITS-1:0]] <= {s_axis.tuser, s_axis.tlast, s_axis.tkeep, s_axis.tdata};
    end
  end

  assign m_axis.tvalid = rd_ptr_q != commit_ptr_q;
  assign {m_axis.tuser, m_axis.tlast, m_axis.tkeep, m_axis.tdata} = mem[rd_ptr_q[ADDR_BITS-1:0]];

  // Output side carries no verdict; input side never backpressures.
  assign m_axis.crc_valid       = 1'b0;
  assign m_axis.crc_pass_fail_n = 1'b0;
  assign m_axis.length_err      = 1'b0;
  assign s_axis.tready          = 1'b1;

  assign good_frames    = good_q;
  assign crc_err_frames = crc_q;
  assign ovf_frames     = ovfc_q;
  assign frame_dropped  = drop_q;

endmodule

// File: tb/tb_aurora_rx_frame_filter.sv
// Self-checking bench for aurora_rx_frame_filter (small FIFO, depth 8).
module tb_aurora_rx_frame_filter;
  localparam int unsigned AB = 3;
  localparam int unsigned CB = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic channel_up = 1'b0;
  always #5 clk = ~clk;

  aurora_rx_frame_filter_if s_if ();
  aurora_rx_frame_filter_if m_if ();

  logic [CB-1:0] good_frames, crc_err_frames, ovf_frames;
  logic          frame_dropped;

  aurora_rx_frame_filter #(.ADDR_BITS(AB), .CNT_BITS(CB)) dut (
    .s_axis_aclk   (clk),
    .aresetn       (rst_n),
    .channel_up    (channel_up),
    .s_axis        (s_if.slave),
    .m_axis        (m_if.master),
    .good_frames   (good_frames),
    .crc_err_frames(crc_err_frames),
    .ovf_frames    (ovf_frames),
    .frame_dropped (frame_dropped)
  );

  typedef logic [37:0] word_t;  // {tuser, tlast, tkeep, tdata}

  typedef struct {
    int          n;
    logic [31:0] base;
    logic [31:0] step;
    bit          cv;
    bit          pass;
    bit          len;
    bit          good;
    int          crc_inc;
    int          ovf_inc;
  } vec_t;

  word_t sb[$];
  int n_vec = 0, n_err = 0, drop_cnt = 0;
  int exp_good = 0, exp_crc = 0, exp_ovf = 0, exp_drop = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Output monitor: pops expected words on each handshake, checks stall stability.
  initial begin
    word_t held, cur, e;
    bit stalled;
    stalled = 1'b0;
    held    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stalled = 1'b0;
      end else begin
        if (frame_dropped) drop_cnt++;
        cur = {m_if.tuser, m_if.tlast, m_if.tkeep, m_if.tdata};
        if (m_if.tvalid) begin
          if (stalled) check("stall_hold", cur, held);
          if (m_if.tready) begin
            e = (sb.size() > 0) ? sb.pop_front() : '0;
            check("out_word", cur, e);
          end
          stalled = !m_if.tready;
          held    = cur;
        end else begin
          if (stalled) check("tvalid_kept_while_stalled", m_if.tvalid, 1);
          stalled = 1'b0;
        end
      end
    end
  end

  task automatic idle_inputs();
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0; s_if.crc_valid = 1'b0;
    s_if.crc_pass_fail_n = 1'b0; s_if.length_err = 1'b0;
  endtask

  // Starts and ends 1 time unit after a rising edge.
  task automatic send_frame(input int n, input logic [31:0] base, input logic [31:0] step,
                            input bit cv, input bit pass, input bit len, input bit good);
    word_t w[$];
    logic  last;
    for (int i = 0; i < n; i++) begin
      last                 = (i == n - 1);
      s_if.tdata           = base + 32'(step * i);
      s_if.tkeep           = last ? 4'h3 : 4'hF;
      s_if.tuser           = i[0];
      s_if.tlast           = last;
      s_if.tvalid          = 1'b1;
      s_if.crc_valid       = last && cv;
      s_if.crc_pass_fail_n = pass;
      s_if.length_err      = last && len;
      w.push_back({s_if.tuser, s_if.tlast, s_if.tkeep, s_if.tdata});
      @(posedge clk); #1;
    end
    idle_inputs();
    if (good) foreach (w[k]) sb.push_back(w[k]);
  endtask

  task automatic drain(output int cyc);
    cyc = 0;
    while (m_if.tvalid && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic check_counters(input string tag);
    repeat (2) begin @(posedge clk); #1; end
    check({tag, "_good_frames"}, good_frames, exp_good);
    check({tag, "_crc_err_frames"}, crc_err_frames, exp_crc);
    check({tag, "_ovf_frames"}, ovf_frames, exp_ovf);
    check({tag, "_drop_pulses"}, drop_cnt, exp_drop);
    check({tag, "_sb_empty"}, sb.size(), 0);
  endtask

  initial begin
    vec_t vecs[8];
    int   cyc;
    bit   pat[8];

    vecs[0] = '{4, 32'h11111111, 32'h11111111, 1, 1, 0, 1, 0, 0};
    vecs[1] = '{4, 32'h11111111, 32'h11111111, 1, 0, 0, 0, 1, 0};  // CRC fail
    vecs[2] = '{4, 32'h11111111, 32'h11111111, 1, 1, 1, 0, 1, 0};  // length error
    vecs[3] = '{3, 32'hA0000000, 32'h1, 0, 1, 0, 0, 1, 0};         // no crc_valid
    vecs[4] = '{1, 32'hB0000000, 32'h1, 1, 1, 0, 1, 0, 0};         // single beat
    vecs[5] = '{8, 32'hC0000000, 32'h3, 1, 1, 0, 1, 0, 0};         // exactly depth
    vecs[6] = '{9, 32'hD0000000, 32'h1, 1, 1, 0, 0, 0, 1};         // longer than depth
    vecs[7] = '{5, 32'hE0000000, 32'h10, 1, 1, 0, 1, 0, 0};

    idle_inputs();
    s_if.tdata = '0; s_if.tkeep = '0; s_if.tuser = 1'b0;
    m_if.tready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", m_if.tvalid, 0);
    check("rst_good", good_frames, 0);
    check("rst_crc", crc_err_frames, 0);
    check("rst_ovf", ovf_frames, 0);
    check("rst_drop", frame_dropped, 0);
    rst_n = 1'b1; channel_up = 1'b1; m_if.tready = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[v]) begin
      send_frame(vecs[v].n, vecs[v].base, vecs[v].step, vecs[v].cv, vecs[v].pass,
                 vecs[v].len, vecs[v].good);
      check($sformatf("v%0d_first_word_valid", v), m_if.tvalid, vecs[v].good);
      drain(cyc);
      check($sformatf("v%0d_burst_len", v), cyc, vecs[v].good ? vecs[v].n : 0);
      exp_good += vecs[v].good ? 1 : 0;
      exp_crc  += vecs[v].crc_inc;
      exp_ovf  += vecs[v].ovf_inc;
      exp_drop += vecs[v].good ? 0 : 1;
      check_counters($sformatf("v%0d", v));
    end

    // Overflow with a stalled consumer: 6-word frame commits, 5-word frame overflows.
    m_if.tready = 1'b0;
    send_frame(6, 32'h60000000, 32'h1, 1, 1, 0, 1);
    send_frame(5, 32'h70000000, 32'h1, 1, 1, 0, 0);
    exp_good++; exp_ovf++; exp_drop++;
    @(posedge clk); #1;
    check("ovf_committed_waiting", m_if.tvalid, 1);
    m_if.tready = 1'b1;
    drain(cyc);
    check("ovf_burst_len", cyc, 6);
    check_counters("ovf");

    // Channel loss after two beats; beats while down are ignored.
    for (int i = 0; i < 2; i++) begin
      s_if.tdata = 32'h80000000 + i; s_if.tkeep = 4'hF; s_if.tuser = 1'b0;
      s_if.tvalid = 1'b1;
      @(posedge clk); #1;
    end
    channel_up = 1'b0;
    s_if.tlast = 1'b1; s_if.crc_valid = 1'b1; s_if.crc_pass_fail_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    idle_inputs();
    channel_up = 1'b1;
    exp_ovf++; exp_drop++;
    check("chan_no_output", m_if.tvalid, 0);
    send_frame(3, 32'h90000000, 32'h1, 1, 1, 0, 1);
    exp_good++;
    drain(cyc);
    check("chan_burst_len", cyc, 3);
    check_counters("chan");

    // Consumer ready toggling 1,0,0,1 while a frame drains.
    pat = '{1, 0, 0, 1, 1, 1, 1, 1};
    send_frame(4, 32'h12345678, 32'h01010101, 1, 1, 0, 1);
    exp_good++;
    foreach (pat[k]) begin
      m_if.tready = pat[k];
      @(posedge clk); #1;
    end
    m_if.tready = 1'b1;
    drain(cyc);
    check_counters("toggle");

    // Asynchronous reset mid-output.
    m_if.tready = 1'b0;
    send_frame(4, 32'hF0000000, 32'h1, 1, 1, 0, 1);
    @(posedge clk); #1;
    check("prerst_tvalid", m_if.tvalid, 1);
    rst_n = 1'b0;
    #1;
    check("midrst_tvalid", m_if.tvalid, 0);
    check("midrst_good", good_frames, 0);
    check("midrst_ovf", ovf_frames, 0);
    check("midrst_crc", crc_err_frames, 0);
    sb.delete();
    exp_good = 0; exp_crc = 0; exp_ovf = 0; exp_drop = 0; drop_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1; m_if.tready = 1'b1;
    @(posedge clk); #1;
    send_frame(vecs[0].n, vecs[0].base, vecs[0].step, 1, 1, 0, 1);
    check("postrst_first_word_valid", m_if.tvalid, 1);
    drain(cyc);
    check("postrst_burst_len", cyc, 4);
    exp_good = 1;
    check_counters("postrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
